// File: rtl/wb_alu_if.sv
// Wishbone classic slave bus for the wb_alu register block.
// Signal names keep the slave-side _i/_o naming used by the ALU documentation.
interface wb_alu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) ();
  logic [ADDR_W-1:0]   adr_i;
  logic [DATA_W-1:0]   dat_i;
  logic [DATA_W-1:0]   dat_o;
  logic                we_i;
  logic [DATA_W/8-1:0] sel_i;
  logic                cyc_i;
  logic                stb_i;
  logic                ack_o;
  logic                err_o;
  logic                rty_o;

  modport slave (
    input  adr_i, dat_i, we_i, sel_i, cyc_i, stb_i,
    output dat_o, ack_o, err_o, rty_o
  );

  modport master (
    output adr_i, dat_i, we_i, sel_i, cyc_i, stb_i,
    input  dat_o, ack_o, err_o, rty_o
  );
endinterface

// File: rtl/wb_alu.sv
// Wishbone-mapped ALU: single-cycle logic/arith ops plus iterative shift-add
// multiply and restoring divide, controlled through a small register file.
module wb_alu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic     clk_i,
  input  logic     rst_i,
  wb_alu_if.slave  bus,
  output logic     done_o
);
  localparam int SEL_W = DATA_W / 8;
  localparam int SH_W  = $clog2(DATA_W);

  localparam logic [ADDR_W-1:0] A_OPA    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_OPB    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_RES_LO = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_RES_HI = ADDR_W'(5);

  typedef enum logic [1:0] {IDLE, EXEC, MULDIV, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_XOR = 4'd4,
    OP_SHL = 4'd5, OP_SHR = 4'd6, OP_MUL = 4'd7, OP_DIV = 4'd8
  } op_t;

  state_t              state;
  logic [DATA_W-1:0]   opa, opb, res_lo, res_hi;
  logic                carry, div0, illegal;
  logic [3:0]          w_op;
  logic [DATA_W-1:0]   w_a, w_b, w_hi, w_lo;
  logic [SH_W-1:0]     cnt;
  logic                ack, err, rty;
  logic [DATA_W-1:0]   dat;

  logic                req, busy, done, bad_adr, ctrl_start;
  logic [3:0]          ctrl_op;
  logic [DATA_W-1:0]   rd_data, status;

  assign busy    = (state == EXEC) || (state == MULDIV);
  assign done    = (state == DONE);
  assign req     = bus.cyc_i && bus.stb_i && !(ack || err || rty);
  assign bad_adr = (bus.adr_i > A_RES_HI) ||
                   (bus.we_i && (bus.adr_i >= A_STATUS));
  assign status  = DATA_W'({illegal, div0, carry, done, busy});
  assign ctrl_op = bus.dat_i[3:0];

  // An 8-bit build has no CTRL bit 8, so it can never start an operation.
  if (DATA_W >= 16) begin : g_start
    assign ctrl_start = bus.dat_i[8];
  end else begin : g_no_start
    assign ctrl_start = 1'b0;
  end

  assign bus.ack_o = ack;
  assign bus.err_o = err;
  assign bus.rty_o = rty;
  assign bus.dat_o = dat;
  assign done_o    = done;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [SEL_W-1:0]  sel
  );
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int i = 0; i < SEL_W; i++)
      if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    rd_data = '0;
    unique case (bus.adr_i)
      A_OPA:    rd_data = opa;
      A_OPB:    rd_data = opb;
      A_STATUS: rd_data = status;
      A_RES_LO: rd_data = res_lo;
      A_RES_HI: rd_data = res_hi;
      default:  rd_data = '0;
    endcase
  end

  logic [DATA_W:0]   sum_ext;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;

  always_comb begin
    sum_ext = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (w_op)
      OP_ADD: begin
        sum_ext = {1'b0, w_a} + {1'b0, w_b};
        alu_res = sum_ext[DATA_W-1:0];
        alu_c   = sum_ext[DATA_W];
      end
      OP_SUB: begin
        sum_ext = {1'b0, w_a} - {1'b0, w_b};
        alu_res = sum_ext[DATA_W-1:0];
        alu_c   = sum_ext[DATA_W];
      end
      OP_AND:  alu_res = w_a & w_b;
      OP_OR:   alu_res = w_a | w_b;
      OP_XOR:  alu_res = w_a ^ w_b;
      OP_SHL:  alu_res = w_a << w_b[SH_W-1:0];
      OP_SHR:  alu_res = w_a >> w_b[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  // One multiply or divide step; w_hi:w_lo is the running product or
  // remainder:dividend/quotient pair.
  logic [DATA_W:0]   mul_sum, div_sh;
  logic              div_ge;
  logic [DATA_W-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_b} : '0);
    div_sh  = {w_hi, w_lo[DATA_W-1]};
    div_ge  = (div_sh >= {1'b0, w_b});
    if (w_op == OP_MUL) begin
      step_hi = mul_sum[DATA_W:1];
      step_lo = {mul_sum[0], w_lo[DATA_W-1:1]};
    end else begin
      step_hi = div_ge ? (div_sh[DATA_W-1:0] - w_b) : div_sh[DATA_W-1:0];
      step_lo = {w_lo[DATA_W-2:0], div_ge};
    end
  end

  // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      // NOTE: the working multiply/divide registers are reset too, so a reset mid-operation leaves nothing stale behind.
      state   <= IDLE;
      opa     <= '0;
      opb     <= '0;
      res_lo  <= '0;
      res_hi  <= '0;
      carry   <= 1'b0;
      div0    <= 1'b0;
      illegal <= 1'b0;
      w_op    <= '0;
      w_a     <= '0;
      w_b     <= '0;
      w_hi    <= '0;
      w_lo    <= '0;
      cnt     <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rty     <= 1'b0;
      dat     <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      rty <= 1'b0;
      dat <= '0;

      case (state)
        EXEC: begin
          res_lo <= alu_res;
          res_hi <= '0;
          carry  <= alu_c;
          state  <= DONE;
        end
        MULDIV: begin
          if (w_op > OP_DIV) begin
            res_lo  <= '0;
            res_hi  <= '0;
            illegal <= 1'b1;
            state   <= DONE;
          end else if (w_op == OP_DIV && w_b == '0) begin
            res_lo <= '1;
            res_hi <= w_a;
            div0   <= 1'b1;
            state  <= DONE;
          end else begin
            w_hi <= step_hi;
            w_lo <= step_lo;
            cnt  <= cnt + 1'b1;
            if (cnt == SH_W'(DATA_W - 1)) begin
              res_hi <= step_hi;
              res_lo <= step_lo;
              state  <= DONE;
            end
          end
        end
        default: ;
      endcase

      if (req) begin
        if (bad_adr) begin
          err <= 1'b1;
        end else if (!bus.we_i) begin
          ack <= 1'b1;
          dat <= rd_data;
        end else if (busy) begin
          rty <= 1'b1;
        end else begin
          ack <= 1'b1;
          if (bus.adr_i == A_OPA) opa <= merge_bytes(opa, bus.dat_i, bus.sel_i);
          if (bus.adr_i == A_OPB) opb <= merge_bytes(opb, bus.dat_i, bus.sel_i);
          if (bus.adr_i == A_CTRL && ctrl_start) begin
            w_op    <= ctrl_op;
            w_a     <= opa;
            w_b     <= opb;
            w_hi    <= '0;
            w_lo    <= opa;
            cnt     <= '0;
            carry   <= 1'b0;
            div0    <= 1'b0;
            illegal <= 1'b0;
            state   <= (ctrl_op <= OP_SHR) ? EXEC : MULDIV;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_alu.sv
// Directed self-checking bench for wb_alu (DATA_W=32) with hand-computed
// expected results for every operation class, bus error/retry and reset.
module tb_wb_alu;
  localparam int RSP_NONE = 0, RSP_ACK = 1, RSP_ERR = 2, RSP_RTY = 3;
  localparam logic [7:0] A_OPA = 8'd0, A_OPB = 8'd1, A_CTRL = 8'd2;
  localparam logic [7:0] A_STATUS = 8'd3, A_RES_LO = 8'd4, A_RES_HI = 8'd5;
  localparam logic [31:0] START = 32'h100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic done;
  int   n_tests = 0;
  int   n_fail  = 0;

  wb_alu_if #(.DATA_W(32), .ADDR_W(8)) bus ();

  wb_alu #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus),
    .done_o (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int resp, output logic [31:0] rdat);
    @(negedge clk);
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = w;
    bus.adr_i = a;
    bus.dat_i = d;
    bus.sel_i = s;
    resp = RSP_NONE;
    rdat = '0;
    for (int i = 0; i < 4 && resp == RSP_NONE; i++) begin
      @(negedge clk);
      if (bus.ack_o) begin
        resp = RSP_ACK;
        rdat = bus.dat_o;
      end else if (bus.err_o) resp = RSP_ERR;
      else if (bus.rty_o) resp = RSP_RTY;
    end
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int exp_resp);
    int resp;
    logic [31:0] rdat;
    xfer(1'b1, a, d, s, resp, rdat);
    check(tag, 64'(resp), 64'(exp_resp));
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    int resp;
    logic [31:0] rdat;
    xfer(1'b0, a, '0, 4'h0, resp, rdat);
    check({tag, "_rsp"}, 64'(resp), 64'(RSP_ACK));
    check(tag, 64'(rdat), 64'(exp));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [31:0] exp_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_st);
    wr({tag, "_wa"}, A_OPA, a, 4'hF, RSP_ACK);
    wr({tag, "_wb"}, A_OPB, b, 4'hF, RSP_ACK);
    wr({tag, "_go"}, A_CTRL, START | 32'(op), 4'hF, RSP_ACK);
    wait_done(tag);
    rd({tag, "_lo"}, A_RES_LO, exp_lo);
    rd({tag, "_hi"}, A_RES_HI, exp_hi);
    rd({tag, "_st"}, A_STATUS, exp_st);
  endtask

  initial begin
    int resp;
    int n;
    logic [31:0] rdat;
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.adr_i = '0;
    bus.dat_i = '0;
    bus.sel_i = '0;

    repeat (3) @(negedge clk);
    check("rst_outs", 64'({bus.ack_o, bus.err_o, bus.rty_o, done}), 64'd0);
    check("rst_dat", 64'(bus.dat_o), 64'd0);
    rst = 1'b1;
    rd("rst_status", A_STATUS, 32'h0);
    rd("rst_opa", A_OPA, 32'h0);

    wr("wr_res_lo", A_RES_LO, 32'h1, 4'hF, RSP_ERR);
    xfer(1'b0, 8'd7, '0, 4'h0, resp, rdat);
    check("rd_adr7", 64'(resp), 64'(RSP_ERR));
    wr("opa_sel1", A_OPA, 32'hAABBCCDD, 4'b0001, RSP_ACK);
    rd("opa_byte0", A_OPA, 32'h000000DD);
    wr("opb_sel6", A_OPB, 32'hAABBCCDD, 4'b0110, RSP_ACK);
    rd("opb_bytes12", A_OPB, 32'h00BBCC00);
    rd("ctrl_rd", A_CTRL, 32'h0);

    run_op("add_carry", 32'hFFFFFFFF, 32'h1, 4'd0, 32'h0, 32'h0, 32'h06);
    wr("ctrl_nostart", A_CTRL, 32'h2, 4'hF, RSP_ACK);
    rd("nostart_status", A_STATUS, 32'h06);
    run_op("add_plain", 32'h7FFFFFFF, 32'h1, 4'd0, 32'h80000000, 32'h0, 32'h02);
    run_op("sub_borrow", 32'd5, 32'd7, 4'd1, 32'hFFFFFFFE, 32'h0, 32'h06);
    wr("opa_in_done", A_OPA, 32'h55, 4'hF, RSP_ACK);
    rd("res_kept", A_RES_LO, 32'hFFFFFFFE);
    run_op("sub", 32'd7, 32'd5, 4'd1, 32'd2, 32'h0, 32'h02);
    run_op("and", 32'hF0F0F0F0, 32'hFF00FF00, 4'd2, 32'hF000F000, 32'h0, 32'h02);
    run_op("or", 32'hF0F0F0F0, 32'hFF00FF00, 4'd3, 32'hFFF0FFF0, 32'h0, 32'h02);
    run_op("xor", 32'hF0F0F0F0, 32'hFF00FF00, 4'd4, 32'h0FF00FF0, 32'h0, 32'h02);
    run_op("shl", 32'h1, 32'h3F, 4'd5, 32'h80000000, 32'h0, 32'h02);
    run_op("shr", 32'h80000000, 32'h4, 4'd6, 32'h08000000, 32'h0, 32'h02);
    run_op("illegal", 32'h12, 32'h34, 4'd9, 32'h0, 32'h0, 32'h12);

    wr("mul_wa", A_OPA, 32'h12345678, 4'hF, RSP_ACK);
    wr("mul_wb", A_OPB, 32'h9ABCDEF0, 4'hF, RSP_ACK);
    wr("mul_go", A_CTRL, START | 32'd7, 4'hF, RSP_ACK);
    n = 0;
    while (!done && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("mul_cycles", 64'(n), 64'd32);
    rd("mul_lo", A_RES_LO, 32'h242D2080);
    rd("mul_hi", A_RES_HI, 32'h0B00EA4E);
    rd("mul_st", A_STATUS, 32'h02);

    run_op("div", 32'd100, 32'd7, 4'd8, 32'd14, 32'd2, 32'h02);
    run_op("div0", 32'd100, 32'd0, 4'd8, 32'hFFFFFFFF, 32'd100, 32'h0A);

    wr("busy_wa", A_OPA, 32'd3, 4'hF, RSP_ACK);
    wr("busy_wb", A_OPB, 32'd5, 4'hF, RSP_ACK);
    wr("busy_go", A_CTRL, START | 32'd7, 4'hF, RSP_ACK);
    wr("busy_opa_rty", A_OPA, 32'hDEAD, 4'hF, RSP_RTY);
    rd("busy_opa_kept", A_OPA, 32'd3);
    rd("busy_status", A_STATUS, 32'h01);
    rd("busy_res_prev", A_RES_LO, 32'hFFFFFFFF);
    wr("busy_ctrl_rty", A_CTRL, START, 4'hF, RSP_RTY);
    wait_done("busy_mul");
    rd("busy_mul_lo", A_RES_LO, 32'd15);
    rd("busy_mul_hi", A_RES_HI, 32'd0);

    wr("abort_wa", A_OPA, 32'h12345678, 4'hF, RSP_ACK);
    wr("abort_wb", A_OPB, 32'h9ABCDEF0, 4'hF, RSP_ACK);
    wr("abort_go", A_CTRL, START | 32'd7, 4'hF, RSP_ACK);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.we_i  = 1'b0;
    bus.adr_i = A_STATUS;
    @(negedge clk);
    check("rst_no_resp", 64'({bus.ack_o, bus.err_o, bus.rty_o}), 64'd0);
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    rst = 1'b1;
    check("abort_done", 64'(done), 64'd0);
    rd("abort_status", A_STATUS, 32'h0);
    rd("abort_lo", A_RES_LO, 32'h0);
    rd("abort_hi", A_RES_HI, 32'h0);
    rd("abort_opa", A_OPA, 32'h0);
    run_op("post_add", 32'd2, 32'd3, 4'd0, 32'd5, 32'h0, 32'h02);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d of %0d comparisons failed so far", n_fail, n_tests);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_alu.md
WB_ALU -- requirements
Module: wb_alu

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, datapath and register width, legal values 8/16/32/64.
REQ-002 The block SHALL have parameter ADDR_W, default 8, Wishbone word-address width.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: synchronous reset, active-low.
REQ-005 The block SHALL have port adr_i, input, ADDR_W bits: register word index.
REQ-006 The block SHALL have ports dat_i (input) and dat_o (output), DATA_W bits each: write data and read data.
REQ-007 The block SHALL have port we_i, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port sel_i, input, DATA_W/8 bits: byte enables, used on operand writes only.
REQ-009 The block SHALL have ports cyc_i and stb_i, input, 1 bit each: Wishbone classic cycle and strobe.
REQ-010 The block SHALL have ports ack_o, err_o and rty_o, output, 1 bit each: bus response.
REQ-011 The block SHALL have port done_o, output, 1 bit: level copy of STATUS.done.

Function
REQ-012 Register map SHALL be: 0 OPA (rw), 1 OPB (rw), 2 CTRL (w; reads 0), 3 STATUS (r), 4 RES_LO (r), 5 RES_HI (r).
- Any other index SHALL return err_o.
- A write to indices 3, 4 or 5 SHALL return err_o.
REQ-013 A request SHALL be cyc_i&stb_i high with no response asserted in the same cycle; it is sampled in cycle n.
- In cycle n+1 exactly one of ack_o/err_o/rty_o SHALL be high, for exactly one cycle.
- Minimum spacing between accepted requests SHALL therefore be 2 cycles.
REQ-014 dat_o SHALL carry read data while ack_o is high and SHALL be 0 otherwise.
REQ-015 OPA/OPB writes SHALL update only the bytes whose sel_i bit is set.
REQ-016 CTRL SHALL decode as: [3:0] opcode, [8] start; start is a self-clearing pulse.
REQ-017 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MUL (unsigned), 8 DIV (unsigned).
- Shift amount SHALL be OPB[log2(DATA_W)-1:0].
REQ-018 The FSM SHALL have states IDLE, EXEC, MULDIV and DONE; reset SHALL enter IDLE.
REQ-019 IDLE or DONE, on a CTRL write with start=1:
- OPA, OPB and opcode SHALL be latched into working registers.
- done SHALL clear and busy SHALL set in the next cycle.
- The FSM SHALL go to EXEC for opcodes 0-6, otherwise to MULDIV.
REQ-020 EXEC SHALL take 1 cycle, write the result, and go to DONE.
- RES_LO = result; RES_HI = 0.
- STATUS.carry = carry-out for ADD, borrow for SUB, 0 otherwise.
REQ-021 MUL SHALL be iterative shift-add over exactly DATA_W cycles in MULDIV.
- RES_HI:RES_LO SHALL hold the 2*DATA_W-bit product.
REQ-022 DIV SHALL be restoring division over exactly DATA_W cycles.
- RES_LO = quotient; RES_HI = remainder.
REQ-023 DIV with OPB=0 SHALL finish in 1 cycle with RES_LO = all-ones, RES_HI = OPA and STATUS.div0 = 1.
REQ-024 Opcodes 9-15 SHALL finish in 1 cycle with results 0 and STATUS.illegal = 1.
REQ-025 STATUS SHALL decode as: [0] busy, [1] done, [2] carry, [3] div0, [4] illegal; other bits 0.
- carry, div0 and illegal SHALL clear on each start.
REQ-026 DONE SHALL hold done=1 until the next start; RES registers SHALL hold their values until that next operation completes.
REQ-027 While busy, writes to OPA, OPB or CTRL SHALL return rty_o with no state change.
- Reads while busy SHALL return ack_o; reads of RES during busy SHALL return the previous result.
REQ-028 A CTRL write with start=0 SHALL return ack_o with no effect.
REQ-029 Writing OPA/OPB while in DONE SHALL NOT alter RES registers.

Reset
REQ-030 When rst_i=0 at a clock edge, all registers SHALL be set to 0, FSM to IDLE, and ack_o/err_o/rty_o/done_o/dat_o to 0.
- This SHALL abort any MULDIV operation in progress.
- No bus response SHALL be issued for a request sampled in the reset cycle.

Verification
REQ-031 DATA_W=32: OPA=0xFFFFFFFF, OPB=1, ADD start -> 2 cycles later STATUS=0x06, RES_LO=0, RES_HI=0.
REQ-032 OPA=0x12345678, OPB=0x9ABCDEF0, MUL -> busy for exactly 32 cycles; RES_HI=0x0B00EA4E, RES_LO=0x242D2080.
REQ-033 OPA=100, OPB=7, DIV -> RES_LO=14, RES_HI=2; with OPB=0 -> RES_LO=0xFFFFFFFF, RES_HI=100, div0=1.
REQ-034 OPA write during MULDIV -> rty_o one cycle, OPA unchanged; STATUS read -> ack_o with busy=1.
REQ-035 rst_i=0 at MUL cycle 10 -> next cycle STATUS=0, RES=0; new ADD afterwards completes correctly.
REQ-036 Write to index 4, read of index 7, and sel_i=0b0001 write of 0xAABBCCDD to OPA=0 -> err_o, err_o, then OPA=0x000000DD.
